// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: debounced start, serve/play/point/over phases and score keeping.
// Outputs paddle_en/ball_en/ball_rst decode the registered state; scores, winner and serve_dir are registered.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int DEB_BITS     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_n,
  input  logic       frame_tick,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       paddle_en,
  output logic       ball_en,
  output logic       ball_rst,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int FMAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);
  localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES - 1);
  localparam logic [FW-1:0] POINT_LAST = FW'(POINT_FRAMES - 1);
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

  logic                sync1, sync2;
  logic                deb_lvl;
  logic [DEB_BITS-1:0] deb_cnt;
  logic                start_press;

  state_t        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    score_l_d, score_r_d;
  logic [1:0]    winner_d;
  logic          serve_dir_d;

  // Idle level of the button is high, so the synchroniser resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= start_n;
      sync2 <= sync1;
    end
  end

  // Accepted level flips only after 2^DEB_BITS consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_lvl <= 1'b1;
      deb_cnt <= '0;
    end else if (sync2 != deb_lvl) begin
      if (deb_cnt == '1) begin
        deb_lvl <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_BITS'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  assign start_press = (sync2 != deb_lvl) && (deb_cnt == '1) && !sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fcnt_q    <= '0;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      winner    <= 2'b00;
      serve_dir <= 1'b1;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      score_l   <= score_l_d;
      score_r   <= score_r_d;
      winner    <= winner_d;
      serve_dir <= serve_dir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    score_l_d   = score_l;
    score_r_d   = score_r;
    winner_d    = winner;
    serve_dir_d = serve_dir;
    case (state_q)
      IDLE: begin
        if (start_press) begin
          state_d   = SERVE;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          winner_d  = 2'b00;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (fcnt_q == SERVE_LAST) state_d = PLAY;
          else                      fcnt_d  = fcnt_q + FW'(1);
        end
      end
      PLAY: begin
        if (miss_l && miss_r) begin
          state_d = POINT;
        end else if (miss_l) begin
          score_r_d   = score_r + 4'd1;
          serve_dir_d = 1'b0;
          if (score_r_d == WIN) begin
            state_d  = OVER;
            winner_d = 2'b10;
          end else begin
            state_d = POINT;
          end
        end else if (miss_r) begin
          score_l_d   = score_l + 4'd1;
          serve_dir_d = 1'b1;
          if (score_l_d == WIN) begin
            state_d  = OVER;
            winner_d = 2'b01;
          end else begin
            state_d = POINT;
          end
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (fcnt_q == POINT_LAST) state_d = SERVE;
          else                      fcnt_d  = fcnt_q + FW'(1);
        end
      end
      OVER: begin
        if (start_press) begin
          state_d     = SERVE;
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          winner_d    = 2'b00;
          serve_dir_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A tick coinciding with a transition belongs to the old state.
    if (state_d != state_q) fcnt_d = '0;
  end

  always_comb begin
    paddle_en = 1'b0;
    ball_en   = 1'b0;
    ball_rst  = 1'b1;
    case (state_q)
      SERVE: paddle_en = 1'b1;
      PLAY: begin
        paddle_en = 1'b1;
        ball_en   = 1'b1;
        ball_rst  = 1'b0;
      end
      POINT:   ball_rst = 1'b0;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule
